// File: rtl/spi_master_ctrl.sv
// SPI master that serialises 10-bit host commands into slave frames and captures read data.
// Optional one-entry command buffer enabled by defining SPI_MASTER_CMD_BUF_EN.
module spi_master_ctrl #(
    parameter int unsigned RD_GAP    = 3,
    parameter int unsigned DESEL_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSel   = 3'd1;
    localparam logic [2:0] StCmd   = 3'd2;
    localparam logic [2:0] StShift = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;
    localparam logic [2:0] StRecv  = 3'd5;
    localparam logic [2:0] StDesel = 3'd6;

    localparam logic [3:0] GapLoad   = 4'(RD_GAP - 1);
    localparam logic [3:0] DeselLoad = 4'(DESEL_CYC - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] f_q, f_d;
    logic       rd_op_q, rd_op_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       cmd_ready_q, cmd_ready_d;

    logic       accept;
    logic       launch;
    logic [9:0] launch_data;

`ifdef SPI_MASTER_CMD_BUF_EN
    logic       buf_valid_q, buf_valid_d;
    logic [9:0] buf_data_q, buf_data_d;
    logic       launch_buf;
`endif

    assign accept = cmd_valid & cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f_d         = f_q;
        rd_op_d     = rd_op_q;
        rx_d        = rx_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        launch      = 1'b0;
        launch_data = cmd_data;
`ifdef SPI_MASTER_CMD_BUF_EN
        launch_buf  = 1'b0;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
`endif

        case (state_q)
            StIdle: begin
                if (accept) launch = 1'b1;
            end
            StSel: state_d = StCmd;
            StCmd: begin
                state_d = StShift;
                cnt_d   = 4'd9;
            end
            StShift: begin
                f_d = {f_q[8:0], 1'b0};
                if (cnt_q == 4'd0) begin
                    state_d = rd_op_q ? StGap : StDesel;
                    cnt_d   = rd_op_q ? GapLoad : DeselLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRecv;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecv: begin
                rx_d = {rx_q[6:0], miso};
                if (cnt_q == 4'd0) begin
                    rd_data_d  = rx_d;
                    rd_valid_d = 1'b1;
                    state_d    = StDesel;
                    cnt_d      = DeselLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDesel: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
`ifdef SPI_MASTER_CMD_BUF_EN
                    // Chain straight into the next frame; a fresh accept bypasses the empty buffer.
                    if (buf_valid_q) begin
                        launch      = 1'b1;
                        launch_buf  = 1'b1;
                        launch_data = buf_data_q;
                    end else if (accept) begin
                        launch = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d = StSel;
            f_d     = launch_data;
            rd_op_d = (launch_data[9:8] == 2'b11);
        end

`ifdef SPI_MASTER_CMD_BUF_EN
        if (launch_buf) buf_valid_d = 1'b0;
        if (accept && !(launch && !launch_buf)) begin
            buf_valid_d = 1'b1;
            buf_data_d  = cmd_data;
        end
`endif

        // Outputs are computed from next state so they register in step with it.
        ss_n_d = (state_d == StIdle) || (state_d == StDesel);
        mosi_d = ((state_d == StCmd) || (state_d == StShift)) ? f_d[9] : 1'b0;
        busy_d = (state_d != StIdle);
`ifdef SPI_MASTER_CMD_BUF_EN
        cmd_ready_d = !buf_valid_d;
`else
        cmd_ready_d = (state_d == StIdle);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            f_q         <= 10'd0;
            rd_op_q     <= 1'b0;
            rx_q        <= 8'd0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f_q         <= f_d;
            rd_op_q     <= rd_op_d;
            rx_q        <= rx_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

`ifdef SPI_MASTER_CMD_BUF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= 10'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    assign cmd_ready = cmd_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: timeline reference model of each frame plus random traffic.
module tb_spi_master_ctrl;

    localparam int unsigned G = 3;
    localparam int unsigned D = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data = 10'd0;
    logic       miso = 1'b0;
    logic       cmd_ready, rd_valid, busy, ss_n, mosi;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rd = 8'h00;

    spi_master_ctrl #(.RD_GAP(G), .DESEL_CYC(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present a command and return just after the accepting edge.
    task automatic send_cmd(input logic [9:0] cmd);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Drives one command and checks the whole frame cycle by cycle against the timeline model.
    task automatic run_frame(input logic [9:0] cmd, input logic [7:0] rx);
        bit is_rd = (cmd[9:8] == 2'b11);
        int L = is_rd ? 20 + G : 12;
        logic [3:0] exp, got;
        logic exp_mosi;
        send_cmd(cmd);
        for (int k = 1; k <= L + D + 1; k++) begin
            @(negedge clk);
            if (k == 2) exp_mosi = cmd[9];
            else if (k >= 3 && k <= 12) exp_mosi = cmd[12 - k];
            else exp_mosi = 1'b0;
            exp = {(k > L), exp_mosi, (k <= L + D), (is_rd && k == L + 1)};
            got = {ss_n, mosi, busy, rd_valid};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL frame cmd=%h cycle %0d: {ss_n,mosi,busy,rd_valid}=%b required %b",
                         cmd, k, got, exp);
            end
            if (is_rd && k > 12 + G && k <= 20 + G) miso = rx[20 + G - k];
            else miso = 1'b0;
        end
        if (is_rd) model_rd = rx;
        checks++;
        if (rd_data !== model_rd || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_end cmd=%h: rd_data=%h cmd_ready=%b required %h 1",
                     cmd, rd_data, cmd_ready, model_rd);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ss_n, mosi, cmd_ready, busy, rd_valid, rd_data} !== {5'b10100, 8'h00}) begin
            errors++;
            $display("FAIL reset: ss_n=%b mosi=%b cmd_ready=%b busy=%b rd_valid=%b rd_data=%h required 1 0 1 0 0 00",
                     ss_n, mosi, cmd_ready, busy, rd_valid, rd_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wr_addr;
        run_frame(10'h0A5, 8'h00);
    endtask

    task automatic test_rd_data;
        run_frame(10'h300, 8'hC3);
        checks++;
        if (rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL rd_c3: rd_data=%h required c3", rd_data);
        end
    endtask

    task automatic test_write_after_read;
        run_frame(10'h1AA, 8'h00);
        checks++;
        if (rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL wr_after_rd: rd_data=%h required c3", rd_data);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [9:0] c = 10'($urandom);
            logic [7:0] r = 8'($urandom);
            run_frame(c, r);
        end
    endtask

    task automatic test_back_to_back;
        int acc_cyc[2];
        int n_acc = 0;
        logic ssq[$];
        int run1 = 0, gap = 0, run2 = 0, end1 = -1, phase = 0, rv = 0;
        int exp_gap;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 10'h1FF;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ssq.push_back(ss_n);
            if (rd_valid === 1'b1) rv++;
            if (cmd_valid && cmd_ready && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc == 1) cmd_data = 10'h2FF;
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < ssq.size(); i++) begin
            if (phase == 0 && ssq[i] == 1'b0) phase = 1;
            if (phase == 1) begin
                if (ssq[i] == 1'b0) run1++;
                else begin phase = 2; end1 = i - 1; end
            end
            if (phase == 2) begin
                if (ssq[i] == 1'b1) gap++;
                else phase = 3;
            end
            if (phase == 3) begin
                if (ssq[i] == 1'b0) run2++;
                else phase = 4;
            end
        end
`ifdef SPI_MASTER_CMD_BUF_EN
        exp_gap = D;
`else
        exp_gap = D + 1;
`endif
        checks++;
        if (n_acc != 2 || run1 != 12 || run2 != 12 || gap != exp_gap || rv != 0) begin
            errors++;
            $display("FAIL b2b: accepts=%0d low1=%0d gap=%0d low2=%0d rd_valid=%0d required 2 12 %0d 12 0",
                     n_acc, run1, gap, run2, rv, exp_gap);
        end
        checks++;
`ifdef SPI_MASTER_CMD_BUF_EN
        if (n_acc != 2 || acc_cyc[1] > end1) begin
`else
        if (n_acc != 2 || acc_cyc[1] != end1 + D + 1) begin
`endif
            errors++;
            $display("FAIL b2b_accept: second accept cycle=%0d first frame end=%0d", acc_cyc[1], end1);
        end
    endtask

    task automatic test_reset_mid_recv;
        int bad = 0;
        // A completed read of 00 makes the held value and the reset value coincide.
        run_frame(10'h300, 8'h00);
        send_cmd(10'h3A5);
        for (int k = 1; k <= 12 + G + 4; k++) begin
            @(negedge clk);
            miso = (k > 12 + G);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ss_n, mosi, busy, rd_valid, cmd_ready, rd_data} !== {5'b10001, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: ss_n=%b mosi=%b busy=%b rd_valid=%b cmd_ready=%b rd_data=%h required 1 0 0 0 1 00",
                     ss_n, mosi, busy, rd_valid, cmd_ready, rd_data);
        end
        rst_n = 1'b1;
        miso  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rd_valid !== 1'b0 || ss_n !== 1'b1) bad++;
        end
        miso = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_idle: %0d cycles with activity required 0", bad);
        end
        run_frame(10'h35A, 8'h5A);
    endtask

    initial begin
        test_reset();
        test_wr_addr();
        test_rd_data();
        test_write_after_read();
        test_back_to_back();
        test_random();
        test_reset_mid_recv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
